// File: rtl/cp0_param_intc_pkg.sv
// CP0 register addresses, field positions, exception codes and vectors.
package cp0_param_intc_pkg;

  typedef enum logic [7:0] {
    A_BADVADDR = 8'h40,
    A_COUNT    = 8'h48,
    A_COMPARE  = 8'h58,
    A_STATUS   = 8'h60,
    A_CAUSE    = 8'h68
  } cp0_addr_e;

  localparam int ST_BEV = 22;
  localparam int ST_IM  = 8;
  localparam int ST_EXL = 1;
  localparam int ST_IE  = 0;

  localparam int CA_BD = 31;
  localparam int CA_TI = 30;
  localparam int CA_IP = 8;
  localparam int CA_EC = 2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] VEC_BOOT = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORM = 32'h8000_0180;

  typedef struct packed {
    logic       bev;
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  function automatic logic [31:0] status_word(status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_BEV] = s.bev;
    w[ST_IM +: 8] = s.im;
    w[ST_EXL] = s.exl;
    w[ST_IE] = s.ie;
    return w;
  endfunction

  function automatic logic is_addr_exc(logic [4:0] c);
    return (c == EXC_ADEL) || (c == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Synchroniser chain for the hardware interrupt lines.
module cp0_int_sync #(
  parameter int W      = 6,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (STAGES == 0) begin : g_direct
    assign q = d;
  end else begin : g_chain
    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
        chain[0] <= d;
        for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

// File: rtl/cp0_param_intc.sv
// CP0 timer, status/cause/EPC/BadVAddr and interrupt arbitration.
// Timer interrupt on Cause.TI/IP[7] enabled by CP0_TIMER_INT_EN.
module cp0_param_intc
  import cp0_param_intc_pkg::*;
#(
  parameter int NUM_HW_INT      = 6,
  parameter int COUNT_DIV       = 2,
  parameter int INT_SYNC_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_HW_INT-1:0] ext_int,
  input  logic                  wen,
  input  logic [7:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_excode,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_epc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  exc_eret,
  output logic                  int_req,
  output logic [31:0]           exc_target,
  output logic [31:0]           epc
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic [31:0]           badvaddr_q;
  logic [31:0]           epc_q;
  logic [DW-1:0]         div_q;
  status_t               st_q;
  logic                  bd_q;
  logic                  ti_q;
  logic [1:0]            ip_sw_q;
  logic [5:0]            ip_hw_q;
  logic [4:0]            ec_q;
  logic [NUM_HW_INT-1:0] int_sync;
  logic [5:0]            hw_pad;
  logic [7:0]            ip;

  logic wr_count, wr_compare, wr_status, wr_cause;
  logic exc, eret;

  cp0_int_sync #(
    .W      (NUM_HW_INT),
    .STAGES (INT_SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (ext_int),
    .q      (int_sync)
  );

  assign hw_pad = 6'(int_sync);

  assign wr_count   = wen && (addr == A_COUNT);
  assign wr_compare = wen && (addr == A_COMPARE);
  assign wr_status  = wen && (addr == A_STATUS);
  assign wr_cause   = wen && (addr == A_CAUSE);
  assign exc        = exc_valid && !exc_eret;
  assign eret       = exc_valid && exc_eret;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q    <= '0;
      compare_q  <= '0;
      badvaddr_q <= '0;
      epc_q      <= '0;
      div_q      <= '0;
      st_q       <= '{bev: 1'b1, im: 8'h00, exl: 1'b0, ie: 1'b0};
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      ec_q       <= '0;
    end else begin
      if (wr_count) begin
        count_q <= wdata;
        div_q   <= '0;
      end else if (div_q == DIV_LAST) begin
        count_q <= count_q + 32'd1;
        div_q   <= '0;
      end else begin
        div_q <= div_q + DW'(1);
      end

      if (wr_compare) compare_q <= wdata;

      if (wr_status) begin
        st_q.bev <= wdata[ST_BEV];
        st_q.im  <= wdata[ST_IM +: 8];
        st_q.exl <= wdata[ST_EXL];
        st_q.ie  <= wdata[ST_IE];
      end

      if (wr_cause) ip_sw_q <= wdata[CA_IP +: 2];
      ip_hw_q <= hw_pad;

      // Later assignments let the exception override an mtc0 on EXL.
      if (exc) begin
        if (!st_q.exl) begin
          epc_q <= exc_epc;
          bd_q  <= exc_bd;
        end
        ec_q     <= exc_excode;
        st_q.exl <= 1'b1;
        if (is_addr_exc(exc_excode)) badvaddr_q <= exc_badvaddr;
      end else if (eret) begin
        st_q.exl <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_INT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ti_q <= 1'b0;
    end else if (wr_compare) begin
      ti_q <= 1'b0;
    end else if (count_q == compare_q) begin
      ti_q <= 1'b1;
    end
  end
`else
  assign ti_q = 1'b0;
`endif

  assign ip = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

  always_comb begin
    rdata = '0;
    case (addr)
      A_BADVADDR: rdata = badvaddr_q;
      A_COUNT:    rdata = count_q;
      A_COMPARE:  rdata = compare_q;
      A_STATUS:   rdata = status_word(st_q);
      A_CAUSE: begin
        rdata[CA_BD] = bd_q;
        rdata[CA_TI] = ti_q;
        rdata[CA_IP +: 8] = ip;
        rdata[CA_EC +: 5] = ec_q;
      end
      default:    rdata = '0;
    endcase
  end

  assign int_req    = (|(ip & st_q.im)) & st_q.ie & ~st_q.exl;
  assign exc_target = st_q.bev ? VEC_BOOT : VEC_NORM;
  assign epc        = epc_q;

endmodule

// File: tb/tb_cp0_param_intc.sv
// Scoreboard bench for cp0_param_intc.
`timescale 1ns/1ps
module tb_cp0_param_intc;
  import cp0_param_intc_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  ext_int;
  logic        wen;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        int_req;
  logic [31:0] exc_target;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  typedef enum int { K_RD, K_IRQ, K_TGT, K_EPC } kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [7:0]  a;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  cp0_param_intc #(
    .NUM_HW_INT      (6),
    .COUNT_DIV       (2),
    .INT_SYNC_STAGES (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ext_int      (ext_int),
    .wen          (wen),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .exc_valid    (exc_valid),
    .exc_excode   (exc_excode),
    .exc_bd       (exc_bd),
    .exc_epc      (exc_epc),
    .exc_badvaddr (exc_badvaddr),
    .exc_eret     (exc_eret),
    .int_req      (int_req),
    .exc_target   (exc_target),
    .epc          (epc)
  );

  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input kind_e k,
                      input logic [7:0] a, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.kind = k;
    x.a = a;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      addr = x.a;
      #1;
      case (x.kind)
        K_RD:    check(x.tag, rdata, x.exp);
        K_IRQ:   check(x.tag, {31'd0, int_req}, x.exp);
        K_TGT:   check(x.tag, exc_target, x.exp);
        default: check(x.tag, epc, x.exp);
      endcase
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    wen = 1'b1;
    addr = a;
    wdata = d;
    cyc();
    wen = 1'b0;
  endtask

  task automatic raise(input logic [4:0] ec, input logic bd,
                       input logic [31:0] pc, input logic [31:0] bad);
    exc_valid = 1'b1;
    exc_excode = ec;
    exc_bd = bd;
    exc_epc = pc;
    exc_badvaddr = bad;
    cyc();
    exc_valid = 1'b0;
  endtask

  task automatic do_eret();
    exc_valid = 1'b1;
    exc_eret = 1'b1;
    cyc();
    exc_valid = 1'b0;
    exc_eret = 1'b0;
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    ext_int = '0;
    wen = 1'b0;
    addr = '0;
    wdata = '0;
    exc_valid = 1'b0;
    exc_excode = '0;
    exc_bd = 1'b0;
    exc_epc = '0;
    exc_badvaddr = '0;
    exc_eret = 1'b0;
    cyc(3);

    push("rst_status", K_RD, A_STATUS, 32'h0040_0000);
    push("rst_cause", K_RD, A_CAUSE, 32'h0);
    push("rst_count", K_RD, A_COUNT, 32'h0);
    push("rst_irq", K_IRQ, 8'h0, 32'h0);
    push("rst_tgt", K_TGT, 8'h0, 32'hBFC0_0380);
    push("rst_epc", K_EPC, 8'h0, 32'h0);
    drain();
    resetn = 1'b1;
    cyc();

    mtc0(A_COUNT, 32'hFFFF_FFFE);
    push("cnt_wr", K_RD, A_COUNT, 32'hFFFF_FFFE);
    drain();
    cyc(2);
    push("cnt_2", K_RD, A_COUNT, 32'hFFFF_FFFF);
    drain();
    cyc(2);
    push("cnt_wrap", K_RD, A_COUNT, 32'h0);
    drain();

    raise(EXC_ADEL, 1'b1, 32'h8000_1000, 32'h1234_5679);
    push("adel_epc", K_EPC, 8'h0, 32'h8000_1000);
    push("adel_cause", K_RD, A_CAUSE, 32'h8000_0010);
    push("adel_status", K_RD, A_STATUS, 32'h0040_0002);
    push("adel_bad", K_RD, A_BADVADDR, 32'h1234_5679);
    drain();
    raise(5'd12, 1'b0, 32'h8000_2000, 32'h0000_DEAD);
    push("nest_epc", K_EPC, 8'h0, 32'h8000_1000);
    push("nest_cause", K_RD, A_CAUSE, 32'h8000_0030);
    push("nest_bad", K_RD, A_BADVADDR, 32'h1234_5679);
    drain();
    do_eret();
    push("eret_status", K_RD, A_STATUS, 32'h0040_0000);
    push("eret_epc", K_EPC, 8'h0, 32'h8000_1000);
    drain();

    mtc0(A_STATUS, 32'h0000_0401);
    push("bev0_tgt", K_TGT, 8'h0, 32'h8000_0180);
    push("bev0_status", K_RD, A_STATUS, 32'h0000_0401);
    drain();
    ext_int = 6'b000001;
    cyc();
    ext_int = '0;
    push("pulse_p1", K_IRQ, 8'h0, 32'h0);
    drain();
    cyc();
    push("pulse_p2", K_IRQ, 8'h0, 32'h1);
    drain();
    cyc();
    push("pulse_p3", K_IRQ, 8'h0, 32'h0);
    drain();
    ext_int = 6'b000001;
    cyc(2);
    push("lvl_irq", K_IRQ, 8'h0, 32'h1);
    drain();
    raise(5'd0, 1'b0, 32'h8000_3000, 32'h0);
    push("exl_block", K_IRQ, 8'h0, 32'h0);
    push("int_epc", K_EPC, 8'h0, 32'h8000_3000);
    drain();
    do_eret();
    push("eret_irq", K_IRQ, 8'h0, 32'h1);
    drain();
    ext_int = '0;
    cyc(2);
    push("lvl_off", K_IRQ, 8'h0, 32'h0);
    drain();

    wen = 1'b1;
    addr = A_STATUS;
    wdata = 32'h0000_0001;
    raise(EXC_ADES, 1'b0, 32'h8000_4000, 32'hBAD0_0004);
    wen = 1'b0;
    push("same_status", K_RD, A_STATUS, 32'h0000_0003);
    push("same_epc", K_EPC, 8'h0, 32'h8000_4000);
    push("same_bad", K_RD, A_BADVADDR, 32'hBAD0_0004);
    push("same_cause", K_RD, A_CAUSE, 32'h0000_0014);
    drain();
    do_eret();

    mtc0(A_STATUS, 32'h0000_0101);
    mtc0(A_CAUSE, 32'h0000_0100);
    push("sw_irq", K_IRQ, 8'h0, 32'h1);
    push("sw_cause", K_RD, A_CAUSE, 32'h0000_0114);
    drain();
    mtc0(A_CAUSE, 32'hFFFF_FFFF);
    push("cause_mask", K_RD, A_CAUSE, 32'h0000_0314);
    drain();
    mtc0(A_STATUS, 32'hFFFF_FFFF);
    push("status_mask", K_RD, A_STATUS, 32'h0040_FF03);
    push("status_tgt", K_TGT, 8'h0, 32'hBFC0_0380);
    drain();
    mtc0(A_BADVADDR, 32'h0);
    push("bad_ro", K_RD, A_BADVADDR, 32'hBAD0_0004);
    push("undecoded", K_RD, 8'h70, 32'h0);
    drain();

    mtc0(A_CAUSE, 32'h0);
    mtc0(A_STATUS, 32'h0000_8001);
    mtc0(A_COMPARE, 32'd10);
    mtc0(A_COUNT, 32'd8);
`ifdef CP0_TIMER_INT_EN
    n = 0;
    while (n < 10 && !int_req) begin
      cyc();
      n++;
    end
    push("ti_lat_ok", K_IRQ, 8'h0, 32'h1);
    drain();
    check("ti_within5", {31'd0, (n <= 5)}, 32'h1);
    push("ti_cause", K_RD, A_CAUSE, 32'h4000_8014);
    drain();
    mtc0(A_COMPARE, 32'd1000);
    push("ti_clr_irq", K_IRQ, 8'h0, 32'h0);
    push("ti_clr_cause", K_RD, A_CAUSE, 32'h0000_0014);
    drain();
`else
    n = 0;
    cyc(8);
    push("noti_cause", K_RD, A_CAUSE, 32'h0000_0014);
    push("noti_irq", K_IRQ, 8'h0, 32'h0);
    push("noti_cmp", K_RD, A_COMPARE, 32'd10);
    drain();
`endif

    resetn = 1'b0;
    mtc0(A_STATUS, 32'h0000_0003);
    resetn = 1'b1;
    push("rst_mid", K_RD, A_STATUS, 32'h0040_0000);
    push("rst_mid_epc", K_EPC, 8'h0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
